// File: rtl/bitcount_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bitcount_pkg: shared types and saturating add for bitcount_stream |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package bitcount_pkg;

  localparam int c_data_w = 8;
  localparam int c_cnt_w  = 16;
  // Widest counter sat_add supports; callers must keep CNT_W <= c_max_w.
  localparam int c_max_w  = 32;

  typedef struct packed {
    logic [c_cnt_w-1:0] ones;
    logic [c_cnt_w-1:0] zeros;
    logic [c_cnt_w-1:0] beats;
    logic               sat;
  } result_t;

  // Result holds the clamped sum in bits [cnt_w-1:0] and the overflow flag
  // in bit cnt_w, so a (cnt_w+1)-bit cast by the caller yields {sat, sum}.
  function automatic logic [c_max_w:0] sat_add(
    input logic [c_max_w-1:0] acc,
    input logic [c_max_w-1:0] inc,
    input int unsigned        cnt_w
  );
    logic [c_max_w:0] sum;
    logic [c_max_w:0] lim;
    logic [c_max_w:0] res;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((c_max_w+1)'(1) << cnt_w) - (c_max_w+1)'(1);
    if (sum > lim) begin
      res = lim | ((c_max_w+1)'(1) << cnt_w);
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitcount_stream_popcount.sv
`default_nettype none
// +------------------------------------------------------------------+
// | popcount: recursive combinational adder-tree population count    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]             i_bits,
  output logic [$clog2(W+1)-1:0]   o_count
);

  localparam int c_ow   = $clog2(W+1);
  localparam int c_lo_w = W / 2;
  localparam int c_hi_w = W - (W / 2);

  generate
    if (W == 1) begin : g_leaf
      assign o_count = i_bits;
    end else begin : g_split
      logic [$clog2(c_lo_w+1)-1:0] w_lo;
      logic [$clog2(c_hi_w+1)-1:0] w_hi;

      popcount #(.W(c_lo_w)) u_lo (
        .i_bits  (i_bits[c_lo_w-1:0]),
        .o_count (w_lo)
      );

      popcount #(.W(c_hi_w)) u_hi (
        .i_bits  (i_bits[W-1:c_lo_w]),
        .o_count (w_hi)
      );

      assign o_count = c_ow'(w_lo) + c_ow'(w_hi);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bitcount_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bitcount_stream: masked ones/zeros/beat counter per packet       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module bitcount_stream
  import bitcount_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_mask,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_ones,
  output logic [CNT_W-1:0]  out_zeros,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_sat
);

  localparam int c_pc_w = $clog2(DATA_W+1);

  logic [c_pc_w-1:0] w_ones_inc;
  logic [c_pc_w-1:0] w_zeros_inc;
  logic [CNT_W:0]    w_ones_sa;
  logic [CNT_W:0]    w_zeros_sa;
  logic [CNT_W:0]    w_beats_sa;
  logic              w_sat_nxt;
  logic              w_accept;

  logic [CNT_W-1:0]  r_acc_ones;
  logic [CNT_W-1:0]  r_acc_zeros;
  logic [CNT_W-1:0]  r_acc_beats;
  logic              r_acc_sat;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_out_ones;
  logic [CNT_W-1:0]  r_out_zeros;
  logic [CNT_W-1:0]  r_out_beats;
  logic              r_out_sat;

  popcount #(.W(DATA_W)) u_pc_ones (
    .i_bits  (in_data & in_mask),
    .o_count (w_ones_inc)
  );

  popcount #(.W(DATA_W)) u_pc_zeros (
    .i_bits  (~in_data & in_mask),
    .o_count (w_zeros_inc)
  );

  // Ready depends only on registered state, never on the input handshake.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_ones_sa  = (CNT_W+1)'(sat_add(c_max_w'(r_acc_ones),  c_max_w'(w_ones_inc),  CNT_W));
  assign w_zeros_sa = (CNT_W+1)'(sat_add(c_max_w'(r_acc_zeros), c_max_w'(w_zeros_inc), CNT_W));
  assign w_beats_sa = (CNT_W+1)'(sat_add(c_max_w'(r_acc_beats), c_max_w'(1),           CNT_W));
  assign w_sat_nxt  = r_acc_sat | w_ones_sa[CNT_W] | w_zeros_sa[CNT_W] | w_beats_sa[CNT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_ones  <= '0;
      r_acc_zeros <= '0;
      r_acc_beats <= '0;
      r_acc_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ones  <= '0;
      r_out_zeros <= '0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
    end else if (clear) begin
      r_acc_ones  <= '0;
      r_acc_zeros <= '0;
      r_acc_beats <= '0;
      r_acc_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_last) begin
          // A new record overrides the consume above, so back-to-back results have no bubble.
          r_out_valid <= 1'b1;
          r_out_ones  <= w_ones_sa[CNT_W-1:0];
          r_out_zeros <= w_zeros_sa[CNT_W-1:0];
          r_out_beats <= w_beats_sa[CNT_W-1:0];
          r_out_sat   <= w_sat_nxt;
          r_acc_ones  <= '0;
          r_acc_zeros <= '0;
          r_acc_beats <= '0;
          r_acc_sat   <= 1'b0;
        end else begin
          r_acc_ones  <= w_ones_sa[CNT_W-1:0];
          r_acc_zeros <= w_zeros_sa[CNT_W-1:0];
          r_acc_beats <= w_beats_sa[CNT_W-1:0];
          r_acc_sat   <= w_sat_nxt;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ones  = r_out_ones;
  assign out_zeros = r_out_zeros;
  assign out_beats = r_out_beats;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_bitcount_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bitcount_stream: directed self-checking bench                 |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_bitcount_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [7:0]  in_mask = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_ones;
  logic [15:0] out_zeros;
  logic [15:0] out_beats;
  logic        out_sat;

  logic        s_clear = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_in_data = '0;
  logic [7:0]  s_in_mask = '0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [3:0]  s_out_ones;
  logic [3:0]  s_out_zeros;
  logic [3:0]  s_out_beats;
  logic        s_out_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitcount_stream #(.DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ones  (out_ones),
    .out_zeros (out_zeros),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  bitcount_stream #(.DATA_W(8), .CNT_W(4)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .clear     (s_clear),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_mask   (s_in_mask),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_ones  (s_out_ones),
    .out_zeros (s_out_zeros),
    .out_beats (s_out_beats),
    .out_sat   (s_out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] m, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input int ones, input int zeros, input int beats, input int sat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ones"},  32'(out_ones),  ones);
    chk({tag, "_zeros"}, 32'(out_zeros), zeros);
    chk({tag, "_beats"}, 32'(out_beats), beats);
    chk({tag, "_sat"},   32'(out_sat),   sat);
  endtask

  initial begin
    // Reset state, with out_ready low so in_ready=1 comes from out_valid=0.
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ones",  32'(out_ones),  32'd0);
    chk("rst_zeros", 32'(out_zeros), 32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Three-beat packet.
    out_ready = 1'b1;
    drive(8'hFF, 8'hFF, 1'b0); tick();
    drive(8'h0F, 8'hFF, 1'b0); tick();
    chk("p1_novalid_early", 32'(out_valid), 32'd0);
    drive(8'h00, 8'hFF, 1'b1); tick();
    idle();
    chk_rec("p1", 12, 12, 3, 0);
    tick();
    chk("p1_consumed", 32'(out_valid), 32'd0);

    // Partial mask, single-beat packet; left pending with out_ready low.
    drive(8'hAA, 8'hF0, 1'b1); tick();
    idle();
    chk_rec("p2", 2, 2, 1, 0);
    out_ready = 1'b0;
    #1;
    chk("p2_stall_ready", 32'(in_ready), 32'd0);

    // Stalled beat of the next packet must not be taken; record stays stable.
    drive(8'h07, 8'hFF, 1'b0); tick();
    chk("p3_stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk_rec("p2_hold", 2, 2, 1, 0);

    // Consume and new last in the same cycle.
    out_ready = 1'b1;
    drive(8'h07, 8'hFF, 1'b1); tick();
    idle();
    chk_rec("p3_b2b", 3, 5, 1, 0);
    tick();
    chk("p3_consumed", 32'(out_valid), 32'd0);

    // Saturating instance: two full beats overflow a 4-bit ones counter.
    s_in_valid = 1'b1; s_in_data = 8'hFF; s_in_mask = 8'hFF; s_in_last = 1'b0;
    tick();
    s_in_last = 1'b1;
    tick();
    s_in_valid = 1'b0; s_in_last = 1'b0;
    chk("s1_valid", 32'(s_out_valid), 32'd1);
    chk("s1_ones",  32'(s_out_ones),  32'd15);
    chk("s1_zeros", 32'(s_out_zeros), 32'd0);
    chk("s1_beats", 32'(s_out_beats), 32'd2);
    chk("s1_sat",   32'(s_out_sat),   32'd1);
    s_in_valid = 1'b1; s_in_data = 8'h01; s_in_last = 1'b1;
    tick();
    s_in_valid = 1'b0; s_in_last = 1'b0;
    chk("s2_ones",  32'(s_out_ones),  32'd1);
    chk("s2_zeros", 32'(s_out_zeros), 32'd7);
    chk("s2_beats", 32'(s_out_beats), 32'd1);
    chk("s2_sat",   32'(s_out_sat),   32'd0);

    // Clear mid-packet drops the partial counts and the beat presented with it.
    drive(8'hFF, 8'hFF, 1'b0); tick();
    drive(8'hFF, 8'hFF, 1'b0); tick();
    clear = 1'b1;
    drive(8'hF0, 8'hFF, 1'b1); tick();
    clear = 1'b0;
    idle();
    chk("clr_dropped_last", 32'(out_valid), 32'd0);
    drive(8'h03, 8'hFF, 1'b1); tick();
    idle();
    chk_rec("p4", 2, 6, 1, 0);

    // Clear discards a pending record.
    out_ready = 1'b0;
    tick();
    chk("p4_pending", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_pending_valid", 32'(out_valid), 32'd0);
    chk("clr_pending_ready", 32'(in_ready),  32'd1);

    // Asynchronous reset mid-packet with non-zero held output data.
    out_ready = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1); tick();
    drive(8'h0F, 8'hFF, 1'b0); tick();
    idle();
    out_ready = 1'b0;
    chk("pre_rst_ones", 32'(out_ones), 32'd8);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ones",  32'(out_ones),  32'd0);
    chk("arst_zeros", 32'(out_zeros), 32'd0);
    chk("arst_beats", 32'(out_beats), 32'd0);
    chk("arst_ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'h01, 8'hFF, 1'b1); tick();
    idle();
    chk_rec("p5", 1, 7, 1, 0);

    // All-zero mask beat adds only to the beat count.
    drive(8'hFF, 8'h00, 1'b0); tick();
    drive(8'h80, 8'hFF, 1'b1); tick();
    idle();
    chk_rec("p6", 1, 7, 2, 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
